// File: rtl/isp_pkg.sv
// Shared constants and state encoding for the in-system programming loader.
package isp_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN_LO = 3'd1,
      ST_LEN_HI = 3'd2,
      ST_DATA   = 3'd3,
      ST_CSUM   = 3'd4,
      ST_RUN    = 3'd5,
      ST_ERROR  = 3'd6
   } isp_state_e;

   function automatic logic is_sync(input logic [7:0] b);
      return b == SYNC_BYTE;
   endfunction

endpackage

// File: rtl/isp_word_assembler.sv
// Packs four little-endian bytes into a 32-bit word; word_valid_o pulses
// for one cycle, the cycle after the fourth byte is taken.
module isp_word_assembler (
   input  logic        clock,
   input  logic        reset,
   input  logic        clear_i,
   input  logic [7:0]  byte_i,
   input  logic        byte_en_i,
   output logic        last_byte_o,
   output logic [31:0] word_o,
   output logic        word_valid_o
);

   logic [1:0]  idx_q;
   logic [23:0] shift_q;
   logic [31:0] word_q;
   logic        word_valid_q;

   // Byte lane capture, word hand-off and one-cycle valid strobe.
   always_ff @(posedge clock) begin
      if (reset) begin
         idx_q        <= 2'd0;
         shift_q      <= 24'd0;
         word_q       <= 32'd0;
         word_valid_q <= 1'b0;
      end else begin
         word_valid_q <= 1'b0;
         if (clear_i) begin
            idx_q <= 2'd0;
         end else if (byte_en_i) begin
            idx_q <= idx_q + 2'd1;
            case (idx_q)
               2'd0:    shift_q[7:0]   <= byte_i;
               2'd1:    shift_q[15:8]  <= byte_i;
               2'd2:    shift_q[23:16] <= byte_i;
               default: begin
                  word_q       <= {byte_i, shift_q};
                  word_valid_q <= 1'b1;
               end
            endcase
         end
      end
   end

   assign last_byte_o  = (idx_q == 2'd3);
   assign word_o       = word_q;
   assign word_valid_o = word_valid_q;

endmodule

// File: rtl/isp_loader.sv
// Byte-stream boot loader: parses a sync/length/data/checksum frame, writes
// the words into the core's instruction memory and then releases the core.
//
//  state     | meaning
//  ----------+--------------------------------------------------------
//  ST_IDLE   | waiting for sync byte, core held in reset
//  ST_LEN_LO | expecting low byte of word count
//  ST_LEN_HI | expecting high byte of word count
//  ST_DATA   | receiving data bytes, 4 per word
//  ST_CSUM   | expecting XOR checksum of all data bytes
//  ST_RUN    | load good, core released (done)
//  ST_ERROR  | checksum mismatch, core kept in reset (error)
module isp_loader
   import isp_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDRESS_BITS = 8,
   parameter int BASE_ADDR    = 0
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [7:0]              byte_in,
   input  logic                    byte_valid,
   output logic                    byte_ready,
   output logic [ADDRESS_BITS-1:0] isp_address,
   output logic [DATA_WIDTH-1:0]   isp_data,
   output logic                    isp_write,
   output logic                    core_reset,
   output logic                    start,
   output logic [ADDRESS_BITS-1:0] prog_address,
   output logic                    done,
   output logic                    error
);

   localparam logic [ADDRESS_BITS-1:0] BASE = ADDRESS_BITS'(BASE_ADDR);

   isp_state_e              state_q, state_d;
   logic [7:0]              len_lo_q, len_lo_d;
   logic [15:0]             words_left_q, words_left_d;
   logic [7:0]              csum_q, csum_d;
   logic [ADDRESS_BITS-1:0] addr_q, addr_d;
   logic                    start_q, start_d;
   logic                    ready_q;

   logic        accept;
   logic        asm_clear;
   logic        asm_en;
   logic        asm_last;
   logic [31:0] asm_word;
   logic        asm_valid;

   assign accept = byte_valid & ready_q;

   isp_word_assembler u_asm (
      .clock        (clock),
      .reset        (reset),
      .clear_i      (asm_clear),
      .byte_i       (byte_in),
      .byte_en_i    (asm_en),
      .last_byte_o  (asm_last),
      .word_o       (asm_word),
      .word_valid_o (asm_valid)
   );

   // State and datapath registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         len_lo_q     <= 8'd0;
         words_left_q <= 16'd0;
         csum_q       <= 8'd0;
         addr_q       <= BASE;
         start_q      <= 1'b0;
         ready_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_lo_q     <= len_lo_d;
         words_left_q <= words_left_d;
         csum_q       <= csum_d;
         addr_q       <= addr_d;
         start_q      <= start_d;
         ready_q      <= 1'b1;
      end
   end

   // Frame parser: next state, word countdown, checksum and address update.
   always_comb begin
      state_d      = state_q;
      len_lo_d     = len_lo_q;
      words_left_d = words_left_q;
      csum_d       = csum_q;
      addr_d       = addr_q;
      start_d      = 1'b0;
      asm_clear    = 1'b0;
      asm_en       = 1'b0;

      // address advances once the pending write has been presented
      if (asm_valid) begin
         addr_d = addr_q + 1'b1;
      end

      case (state_q)
         ST_IDLE, ST_RUN, ST_ERROR: begin
            if (accept && is_sync(byte_in)) begin
               state_d      = ST_LEN_LO;
               csum_d       = 8'd0;
               words_left_d = 16'd0;
               addr_d       = BASE;
               asm_clear    = 1'b1;
            end
         end
         ST_LEN_LO: begin
            if (accept) begin
               len_lo_d = byte_in;
               state_d  = ST_LEN_HI;
            end
         end
         ST_LEN_HI: begin
            if (accept) begin
               words_left_d = {byte_in, len_lo_q};
               state_d      = ({byte_in, len_lo_q} == 16'd0) ? ST_CSUM : ST_DATA;
            end
         end
         ST_DATA: begin
            if (accept) begin
               asm_en = 1'b1;
               csum_d = csum_q ^ byte_in;
               if (asm_last) begin
                  words_left_d = words_left_q - 16'd1;
                  if (words_left_q == 16'd1) begin
                     state_d = ST_CSUM;
                  end
               end
            end
         end
         ST_CSUM: begin
            if (accept) begin
               if (byte_in == csum_q) begin
                  state_d = ST_RUN;
                  start_d = 1'b1;
               end else begin
                  state_d = ST_ERROR;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign byte_ready   = ready_q;
   assign isp_address  = addr_q;
   assign isp_data     = asm_word;
   assign isp_write    = asm_valid;
   assign core_reset   = (state_q != ST_RUN);
   assign start        = start_q;
   assign prog_address = BASE;
   assign done         = (state_q == ST_RUN);
   assign error        = (state_q == ST_ERROR);

endmodule

// File: tb/tb_isp_loader.sv
// Directed bench for isp_loader: default instance plus a 2-bit address
// instance for the wrap case.
module tb_isp_loader;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset;
   logic [7:0]  byte_in, byte_in2;
   logic        byte_valid, byte_valid2;

   logic        byte_ready, isp_write, core_reset, start, done, error;
   logic [7:0]  isp_address, prog_address;
   logic [31:0] isp_data;

   logic        byte_ready2, isp_write2, core_reset2, start2, done2, error2;
   logic [1:0]  isp_address2, prog_address2;
   logic [31:0] isp_data2;

   isp_loader dut (
      .clock        (clock),
      .reset        (reset),
      .byte_in      (byte_in),
      .byte_valid   (byte_valid),
      .byte_ready   (byte_ready),
      .isp_address  (isp_address),
      .isp_data     (isp_data),
      .isp_write    (isp_write),
      .core_reset   (core_reset),
      .start        (start),
      .prog_address (prog_address),
      .done         (done),
      .error        (error)
   );

   isp_loader #(.ADDRESS_BITS(2)) dut2 (
      .clock        (clock),
      .reset        (reset),
      .byte_in      (byte_in2),
      .byte_valid   (byte_valid2),
      .byte_ready   (byte_ready2),
      .isp_address  (isp_address2),
      .isp_data     (isp_data2),
      .isp_write    (isp_write2),
      .core_reset   (core_reset2),
      .start        (start2),
      .prog_address (prog_address2),
      .done         (done2),
      .error        (error2)
   );

   int errors = 0;
   int checks = 0;

   // write / start logs, sampled on the falling edge
   int          cyc = 0;
   int          wr_n = 0;
   logic [7:0]  wr_addr [16];
   logic [31:0] wr_data [16];
   int          wr_cyc  [16];
   int          start_cnt = 0;
   logic        start_cr = 1'b1;
   int          wr2_n = 0;
   logic [1:0]  wr2_addr [16];
   logic [31:0] wr2_data [16];
   int          start2_cnt = 0;

   logic [7:0] body_a [11] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                               8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C};

   always @(negedge clock) begin
      cyc++;
      if (isp_write && wr_n < 16) begin
         wr_addr[wr_n] = isp_address;
         wr_data[wr_n] = isp_data;
         wr_cyc[wr_n]  = cyc;
         wr_n++;
      end
      if (start) begin
         start_cnt++;
         start_cr = core_reset;
      end
      if (isp_write2 && wr2_n < 16) begin
         wr2_addr[wr2_n] = isp_address2;
         wr2_data[wr2_n] = isp_data2;
         wr2_n++;
      end
      if (start2) start2_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      byte_in    = b;
      byte_valid = 1'b1;
      @(negedge clock);
   endtask

   task automatic send2(input logic [7:0] b);
      byte_in2    = b;
      byte_valid2 = 1'b1;
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      byte_valid  = 1'b0;
      byte_valid2 = 1'b0;
      repeat (n) @(negedge clock);
   endtask

   task automatic clear_log();
      wr_n       = 0;
      start_cnt  = 0;
      wr2_n      = 0;
      start2_cnt = 0;
      start_cr   = 1'b1;
   endtask

   task automatic send_body_a(input logic [7:0] cs);
      for (int i = 0; i < 10; i++) send(body_a[i]);
      send(cs);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset       = 1'b1;
      byte_in     = 8'h00;
      byte_valid  = 1'b0;
      byte_in2    = 8'h00;
      byte_valid2 = 1'b0;
      repeat (3) @(negedge clock);

      // reset values
      check("rst_byte_ready", byte_ready, 0);
      check("rst_isp_write", isp_write, 0);
      check("rst_isp_data", isp_data, 0);
      check("rst_isp_address", isp_address, 0);
      check("rst_start", start, 0);
      check("rst_core_reset", core_reset, 1);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_prog_address", prog_address, 0);
      check("rst_byte_ready2", byte_ready2, 0);
      check("rst_prog_address2", prog_address2, 0);

      reset = 1'b0;
      @(negedge clock);
      check("ready_after_rst", byte_ready, 1);

      // good two-word frame
      clear_log();
      send(8'hA5);
      send_body_a(8'h7C);
      idle(3);
      check("a_wr_n", wr_n, 2);
      check("a_addr0", wr_addr[0], 0);
      check("a_data0", wr_data[0], 32'h00000013);
      check("a_addr1", wr_addr[1], 1);
      check("a_data1", wr_data[1], 32'h0000006F);
      check("a_wr_spacing", wr_cyc[1] - wr_cyc[0], 4);
      check("a_start_cnt", start_cnt, 1);
      check("a_start_core_reset", start_cr, 0);
      check("a_done", done, 1);
      check("a_core_reset", core_reset, 0);
      check("a_error", error, 0);

      // same frame, bad checksum, started from RUN
      clear_log();
      send(8'hA5);
      check("b_rearm_core_reset", core_reset, 1);
      check("b_rearm_done", done, 0);
      send_body_a(8'h00);
      idle(3);
      check("b_wr_n", wr_n, 2);
      check("b_data0", wr_data[0], 32'h00000013);
      check("b_data1", wr_data[1], 32'h0000006F);
      check("b_error", error, 1);
      check("b_done", done, 0);
      check("b_core_reset", core_reset, 1);
      check("b_start_cnt", start_cnt, 0);

      // empty frame, started from ERROR
      clear_log();
      send(8'hA5);
      check("c_rearm_error", error, 0);
      send(8'h00);
      send(8'h00);
      send(8'h00);
      idle(3);
      check("c_wr_n", wr_n, 0);
      check("c_start_cnt", start_cnt, 1);
      check("c_done", done, 1);
      check("c_error", error, 0);
      check("c_core_reset", core_reset, 0);

      // byte lane order within a word
      clear_log();
      send(8'hA5); send(8'h01); send(8'h00);
      send(8'h78); send(8'h56); send(8'h34); send(8'h12);
      send(8'h08);
      idle(3);
      check("e_wr_n", wr_n, 1);
      check("e_addr0", wr_addr[0], 0);
      check("e_data0", wr_data[0], 32'h12345678);
      check("e_done", done, 1);

      // leading garbage before sync, from IDLE
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      @(negedge clock);
      clear_log();
      send(8'h11);
      send(8'h22);
      idle(2);
      check("d_garbage_wr_n", wr_n, 0);
      check("d_garbage_core_reset", core_reset, 1);
      check("d_garbage_done", done, 0);
      send(8'hA5);
      send_body_a(8'h7C);
      idle(3);
      check("d_wr_n", wr_n, 2);
      check("d_data0", wr_data[0], 32'h00000013);
      check("d_data1", wr_data[1], 32'h0000006F);
      check("d_addr1", wr_addr[1], 1);
      check("d_done", done, 1);

      // 2-bit address space, five words: fifth lands at address 0
      clear_log();
      send2(8'hA5); send2(8'h05); send2(8'h00);
      for (int w = 1; w <= 5; w++) begin
         send2(8'(w)); send2(8'h00); send2(8'h00); send2(8'h00);
      end
      send2(8'h01);
      idle(3);
      check("w_wr_n", wr2_n, 5);
      check("w_addr3", wr2_addr[3], 3);
      check("w_addr4", wr2_addr[4], 0);
      check("w_data4", wr2_data[4], 32'h00000005);
      check("w_done", done2, 1);
      check("w_error", error2, 0);
      check("w_core_reset", core_reset2, 0);
      check("w_start_cnt", start2_cnt, 1);

      // reset after six data bytes, then a full frame
      clear_log();
      send(8'hA5); send(8'h02); send(8'h00);
      send(8'h13); send(8'h00); send(8'h00); send(8'h00);
      send(8'h6F); send(8'h00);
      reset = 1'b1;
      idle(2);
      check("r_byte_ready", byte_ready, 0);
      check("r_isp_write", isp_write, 0);
      check("r_isp_data", isp_data, 0);
      check("r_isp_address", isp_address, 0);
      check("r_core_reset", core_reset, 1);
      check("r_done", done, 0);
      check("r_error", error, 0);
      check("r_start", start, 0);
      check("r_partial_wr_n", wr_n, 1);
      reset = 1'b0;
      @(negedge clock);
      clear_log();
      send(8'hA5);
      send_body_a(8'h7C);
      idle(3);
      check("r_wr_n", wr_n, 2);
      check("r_addr0", wr_addr[0], 0);
      check("r_data0", wr_data[0], 32'h00000013);
      check("r_addr1", wr_addr[1], 1);
      check("r_data1", wr_data[1], 32'h0000006F);
      check("r_start_cnt", start_cnt, 1);
      check("r_done_final", done, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/isp_loader.md
ISP_LOADER -- requirements
Module: isp_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of isp_data (fixed at 32 for this block).
REQ-002 Parameter ADDRESS_BITS, default 8, width of isp_address and prog_address.
REQ-003 Parameter BASE_ADDR, default 0, first word address written and the value driven on prog_address.
REQ-004 clock  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 byte_in  input  8  incoming programming byte.
REQ-007 byte_valid  input  1  byte_in valid; a byte is accepted when byte_valid and byte_ready are both high.
REQ-008 byte_ready  output  1  loader can accept a byte this cycle.
REQ-009 isp_address  output  ADDRESS_BITS  word address to the core's instruction memory.
REQ-010 isp_data  output  32  instruction word to write.
REQ-011 isp_write  output  1  one-cycle write strobe.
REQ-012 core_reset  output  1  holds the core in reset while high.
REQ-013 start  output  1  one-cycle pulse that launches the core.
REQ-014 prog_address  output  ADDRESS_BITS  core start address, constant BASE_ADDR.
REQ-015 done  output  1  last load succeeded; core running.
REQ-016 error  output  1  last load failed its checksum.

Function
REQ-017 Frame format: sync 0xA5, LEN_LO, LEN_HI (16-bit word count N), 4*N data bytes (little-endian per word), CSUM byte.
REQ-018 States: IDLE, LEN_LO, LEN_HI, DATA, CSUM, RUN, ERROR.
REQ-019 IDLE: accepted 0xA5 -> LEN_LO, with the running XOR cleared, the byte counter cleared and the address set to BASE_ADDR; any other accepted byte is discarded.
REQ-020 LEN_LO -> LEN_HI, and LEN_HI -> DATA, on each accepted byte; if N == 0, LEN_HI goes directly to CSUM.
REQ-021 DATA: each accepted byte is shifted into bits [8k+7:8k] of the word, where k = byte index mod 4, and XORed into the running checksum.
REQ-022 On acceptance of the 4th byte of a word: on the next cycle, isp_write = 1 for exactly 1 cycle, with isp_data = the assembled word and isp_address = the current word address; the address then increments by 1.
REQ-023 Address increments modulo 2^ADDRESS_BITS; when N exceeds the memory depth, the address wraps without error.
REQ-024 After the N-th word has been accepted: DATA -> CSUM.
REQ-025 CSUM: accepted byte equal to the running XOR -> RUN; otherwise -> ERROR.
REQ-026 Entering RUN: core_reset falls in the same cycle that start pulses high for 1 cycle; done = 1.
REQ-027 Entering ERROR: error = 1; core_reset stays 1; start stays 0.
REQ-028 RUN/ERROR: accepted 0xA5 -> LEN_LO; core_reset = 1, done = 0 and error = 0 from the next cycle; other bytes are discarded.
REQ-029 byte_ready = 1 in every state except the reset cycle; the loader never stalls, because a write completes within the 4 cycles a word needs.
REQ-030 isp_write and the final byte of the next word never collide; a pending write always drains in the cycle after assembly.
REQ-031 core_reset = 1 in every state except RUN.

Reset
REQ-032 During reset: state = IDLE, byte_ready = 0, isp_write = 0, isp_data = 0, isp_address = BASE_ADDR, start = 0, core_reset = 1, done = 0, error = 0, checksum = 0, counters = 0.
REQ-033 Reset mid-frame abandons the frame; words already written are not rolled back.

Structure
REQ-034 Sync value 0xA5 and the state encoding live in a shared package, isp_pkg.
REQ-035 Byte-to-word assembly is one sub-module, isp_word_assembler (byte in, 32-bit word plus word_valid out).
REQ-036 Total RTL size is 120-400 lines.

Verification
REQ-037 Frame A5 02 00 13 00 00 00 6F 00 00 00 7C -> writes 0x00000013 @0 and 0x0000006F @1; start pulses once; done = 1; core_reset = 0.
REQ-038 Same frame with CSUM 0x00 -> both words written, then error = 1, start never pulses, core_reset = 1.
REQ-039 Frame A5 00 00 00 (N = 0) -> no isp_write; start pulses; done = 1.
REQ-040 Leading garbage 11 22 before the sync byte -> ignored; the frame then loads as in REQ-037.
REQ-041 With ADDRESS_BITS = 2 and N = 5 -> word 5 written at address 0 (wrap).
REQ-042 reset asserted after 6 data bytes, then a full frame -> state returns to IDLE, all outputs at reset values, and the new frame loads correctly.
